// File: rtl/vm_pkg.sv
// vm_pkg: coin values, packed coin-vector field offsets and acceptor state shared by the vending machine.
package vm_pkg;
  localparam logic [7:0] VALOR_25 = 8'd25;
  localparam logic [7:0] VALOR_50 = 8'd50;
  localparam logic [7:0] VALOR_100 = 8'd100;
  localparam logic [4:0] OFS_25 = 5'd0;
  localparam logic [4:0] OFS_50 = 5'd8;
  localparam logic [4:0] OFS_100 = 5'd16;
  typedef enum logic [1:0] {OCIOSO, ACEITANDO, CONGELADO} estado_t;
endpackage

// File: rtl/bin2bcd_8.sv
// bin2bcd_8: combinational 8-bit binary to 3-digit BCD (double dabble).
module bin2bcd_8 (
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_o
);
  logic [19:0] s;
  always_comb begin
    s = {12'd0, bin_i};
    for (int i = 0; i < 8; i++) begin
      s[11:8] = s[11:8] >= 4'd5 ? s[11:8] + 4'd3 : s[11:8];
      s[15:12] = s[15:12] >= 4'd5 ? s[15:12] + 4'd3 : s[15:12];
      s[19:16] = s[19:16] >= 4'd5 ? s[19:16] + 4'd3 : s[19:16];
      s = s << 1;
    end
    bcd_o = s[19:8];
  end
endmodule

// File: rtl/aceitador_moedas.sv
// aceitador_moedas: synchronises coin sensors, accumulates value/counts, freezes them for the controller.
// Optional BCD display outputs under ACEITADOR_BCD_EN.
module aceitador_moedas
  import vm_pkg::*;
#(
  parameter int LIMITE_VALOR  = 200,
  parameter int LIMITE_MOEDAS = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        moeda_25,
  input  logic        moeda_50,
  input  logic        moeda_100,
  input  logic        habilitar,
  input  logic        fechar,
  input  logic        confirmar,
  input  logic        cancelar,
  output logic [7:0]  dinheiro_inserido,
  output logic [23:0] moedas_inseridas,
  output logic        pronto,
  output logic        moeda_rejeitada,
  output logic        devolver,
  output logic [23:0] moedas_devolvidas
`ifdef ACEITADOR_BCD_EN
  ,
  output logic [3:0]  dinheiro_inserido_c,
  output logic [3:0]  dinheiro_inserido_d,
  output logic [3:0]  dinheiro_inserido_u
`endif
);
  estado_t     estado_q;
  logic [2:0]  sync1_q, sync2_q, prev_q, pulso;
  logic [7:0]  dinheiro_q, valor, cnt;
  logic [23:0] moedas_q, devolvidas_q;
  logic [4:0]  off;
  logic [8:0]  soma;
  logic        pronto_q, rejeitada_q, devolver_q, aceita;
  always_comb begin
    pulso = sync2_q & ~prev_q;
    valor = pulso[0] ? VALOR_25 : pulso[1] ? VALOR_50 : VALOR_100;
    off = pulso[0] ? OFS_25 : pulso[1] ? OFS_50 : OFS_100;
    cnt = moedas_q[off +: 8];
    soma = {1'b0, dinheiro_q} + {1'b0, valor};
    // a coin arriving with fechar/cancelar is dropped because the state is leaving ACEITANDO
    aceita = estado_q == ACEITANDO && !cancelar && !fechar && $onehot(pulso)
             && soma <= 9'(LIMITE_VALOR) && cnt < 8'(LIMITE_MOEDAS);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q <= '0;
      dinheiro_q <= '0;
      moedas_q <= '0;
      devolvidas_q <= '0;
      pronto_q <= 1'b0;
      rejeitada_q <= 1'b0;
      devolver_q <= 1'b0;
    end else begin
      sync1_q <= {moeda_100, moeda_50, moeda_25};
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      rejeitada_q <= |pulso && !aceita;
      devolver_q <= 1'b0;
      devolvidas_q <= '0;
      case (estado_q)
        OCIOSO: if (habilitar) estado_q <= ACEITANDO;
        ACEITANDO, CONGELADO: begin
          if (cancelar) begin
            estado_q <= OCIOSO;
            devolver_q <= 1'b1;
            devolvidas_q <= moedas_q;
            dinheiro_q <= '0;
            moedas_q <= '0;
            pronto_q <= 1'b0;
          end else if (estado_q == CONGELADO && confirmar) begin
            estado_q <= OCIOSO;
            dinheiro_q <= '0;
            moedas_q <= '0;
            pronto_q <= 1'b0;
          end else if (estado_q == ACEITANDO && fechar) begin
            estado_q <= CONGELADO;
            pronto_q <= 1'b1;
          end else if (aceita) begin
            dinheiro_q <= dinheiro_q + valor;
            moedas_q[off +: 8] <= cnt + 8'd1;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end
  assign dinheiro_inserido = dinheiro_q;
  assign moedas_inseridas = moedas_q;
  assign pronto = pronto_q;
  assign moeda_rejeitada = rejeitada_q;
  assign devolver = devolver_q;
  assign moedas_devolvidas = devolvidas_q;
`ifdef ACEITADOR_BCD_EN
  logic [11:0] bcd, bcd_q;
  bin2bcd_8 u_bcd (.bin_i(dinheiro_q), .bcd_o(bcd));
  always_ff @(posedge clock) bcd_q <= reset ? 12'd0 : bcd;
  assign {dinheiro_inserido_c, dinheiro_inserido_d, dinheiro_inserido_u} = bcd_q;
`endif
endmodule
